adc_readout_spi: RTL
====================

ADC_READOUT_SPI -- requirements
Module: adc_readout_spi

Interface
REQ-001 Parameter WORD_W, default 32, width of each captured ADC count word.
REQ-002 Parameter SYNC_STAGES, default 3, synchroniser depth for spi_sclk and spi_cs_n.
REQ-003 clk  input  1  system clock; all logic is in this domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 result_valid  input  1  one-cycle pulse from the conversion controller when a conversion completes.
REQ-006 count_up, count_down, count_rundown, count_osc  input  WORD_W each  conversion results, valid in the cycle where result_valid is high.
REQ-007 spi_cs_n  input  1  MCU chip select, active low, asynchronous to clk.
REQ-008 spi_sclk  input  1  MCU SPI clock in mode 0, asynchronous to clk, at most clk/8.
REQ-009 spi_miso  output  1  serial result data, MSB first.
REQ-010 data_rdy  output  1  high while an unread result is held; this is the MCU interrupt.

Function
REQ-011 spi_cs_n and spi_sclk SHALL each pass through a SYNC_STAGES shift register; edges SHALL be detected on the two oldest stages.
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and FINISH.
REQ-013 Holding register: a status byte followed by count_up, count_down, count_rundown and count_osc.
- Status bit 7 = overrun; bits 6:4 = seq; bits 3:0 = 0.
- Frame length FRAME_BITS = 8 + 4*WORD_W, which is 136 with defaults.
REQ-014 result_valid outside SHIFT, with no unread result held:
- load holding;
- increment seq (3 bits, wraps 7 to 0);
- set data_rdy on the next cycle.
REQ-015 result_valid outside SHIFT, with data_rdy already high: overwrite holding, increment seq, and set the sticky overrun flag.
REQ-016 result_valid during SHIFT: store in a single pending buffer; if pending is already full, overwrite it and set overrun.
REQ-017 In IDLE, a detected falling edge of cs_n SHALL:
- copy holding into the shift register;
- drive its MSB on spi_miso;
- clear the bit counter;
- enter SHIFT.
REQ-018 In SHIFT, each detected sclk falling edge SHALL shift the register by one and increment the bit counter.
- Bits beyond the frame length SHALL shift out as 0.
- The bit counter SHALL saturate.
REQ-019 A detected cs_n rising edge SHALL move the FSM to FINISH.
REQ-020 In FINISH, if the bit counter is at least the frame length:
- clear data_rdy and overrun;
- if pending is full, move it to holding and set data_rdy.
REQ-021 In FINISH, if the frame was short, holding and data_rdy SHALL be kept unchanged.
REQ-022 FINISH SHALL always return to IDLE after one cycle.
REQ-023 If result_valid arrives in the FINISH cycle, it SHALL be applied after the pending transfer, following REQ-014 and REQ-015.
REQ-024 If result_valid coincides with a cs_n falling detection, the old holding value is shifted out and the new result goes to pending.
REQ-025 spi_miso SHALL be 0 whenever the FSM is not in SHIFT.
REQ-026 Timing the MCU must meet:
- after cs_n falls, wait at least SYNC_STAGES+1 clk periods before the first sclk rising edge;
- sample spi_miso on sclk rising edges.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear the following, with no clock required:
- data_rdy, spi_miso;
- seq, overrun;
- pending-full flag, holding, shift register, bit counter, synchronisers.
- The FSM SHALL go to IDLE.
REQ-028 Synchroniser stages SHALL reset to their idle values: cs_n = 1, sclk = 0.
REQ-029 Reset during SHIFT SHALL abandon the frame; the first result_valid after reset yields seq = 1.

Configuration
REQ-030 With ADC_READOUT_CRC_EN defined, a CRC-8 byte SHALL be appended to the frame.
- Polynomial 0x07, initial value 0x00.
- The CRC covers the status byte and all four words, and is computed when holding is loaded.
- FRAME_BITS becomes 144.
REQ-031 Without ADC_READOUT_CRC_EN, no CRC logic SHALL exist and FRAME_BITS is 136.

Structure
REQ-032 Package adc_readout_pkg SHALL hold:
- FRAME_BITS;
- the status bit positions;
- the CRC polynomial;
- the FSM state encoding.
REQ-033 Sub-module spi_edge_sync SHALL contain the synchroniser and edge detect; it is instantiated once for cs_n and once for sclk.

Verification
REQ-034 Basic read:
- Stimulus: result_valid with up=0x00001234, down=0x00000FFF, rundown=0x0000002A, osc=0x00002710; then a full read at clk/8.
- Required: MISO carries 0x10 then the four words MSB first; data_rdy drops after cs_n rises.
REQ-035 Overrun:
- Stimulus: two result_valid pulses with no read between them.
- Required: the read returns status 0xA0 and the second result; overrun is clear on the following read.
REQ-036 Result during a read:
- Stimulus: result_valid at bit 40 of a read.
- Required: the in-progress frame is unchanged; after cs_n rises, data_rdy re-asserts within 2 cycles and the next read returns the new data with seq+1.
REQ-037 Short read:
- Stimulus: cs_n rises after 20 bits.
- Required: data_rdy stays high; a re-read returns an identical frame.
REQ-038 Reset mid-read:
- Stimulus: rst_n pulsed low at bit 70.
- Required: MISO = 0, data_rdy = 0; the next result gives status 0x10.
REQ-039 CRC build:
- Stimulus: ADC_READOUT_CRC_EN defined; all words 0, seq = 1.
- Required: byte 17 equals the CRC-8 computed by the reference model over 0x10 followed by 16 zero bytes.

Source files
------------

// File: rtl/adc_readout_pkg.sv
// Shared constants for the ADC result SPI readout: status layout, CRC polynomial, frame sizing, FSM states.
package adc_readout_pkg;

  localparam int STATUS_W       = 8;
  localparam int STATUS_OVR_BIT = 7;
  localparam int STATUS_SEQ_HI  = 6;
  localparam int STATUS_SEQ_LO  = 4;

  localparam logic [7:0] CRC_POLY = 8'h07;

`ifdef ADC_READOUT_CRC_EN
  localparam int CRC_W = 8;
`else
  localparam int CRC_W = 0;
`endif

  function automatic int frame_bits(input int word_w);
    return STATUS_W + 4 * word_w + CRC_W;
  endfunction

  localparam int FRAME_BITS = frame_bits(32);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for an asynchronous SPI pin with rise/fall detect on the two oldest stages.
module spi_edge_sync #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], async_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign rise = sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/adc_readout_spi.sv
// Holds the latest ADC conversion and serialises it to an MCU over SPI mode 0 (slave, MSB first).
// Define ADC_READOUT_CRC_EN to append a CRC-8 byte to every frame.
module adc_readout_spi
  import adc_readout_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              result_valid,
  input  logic [WORD_W-1:0] count_up,
  input  logic [WORD_W-1:0] count_down,
  input  logic [WORD_W-1:0] count_rundown,
  input  logic [WORD_W-1:0] count_osc,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  output logic              spi_miso,
  output logic              data_rdy
);

  localparam int PAYLOAD_W = STATUS_W + 4 * WORD_W;
  localparam int FRAME_W   = frame_bits(WORD_W);
  localparam int CNT_W     = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

  logic cs_rise, cs_fall, sclk_fall, sclk_rise_unused;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .async_in(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .async_in(spi_sclk), .rise(sclk_rise_unused), .fall(sclk_fall)
  );

`ifdef ADC_READOUT_CRC_EN
  function automatic logic [7:0] crc8(input logic [PAYLOAD_W-1:0] p);
    logic [7:0] c;
    c = 8'h00;
    for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
      if (c[7] ^ p[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  function automatic logic [FRAME_W-1:0] build_frame(input logic [4*WORD_W-1:0] w,
                                                     input logic [2:0] s, input logic o);
    logic [STATUS_W-1:0]  st;
    logic [PAYLOAD_W-1:0] p;
    st = '0;
    st[STATUS_OVR_BIT] = o;
    st[STATUS_SEQ_HI:STATUS_SEQ_LO] = s;
    p = {st, w};
`ifdef ADC_READOUT_CRC_EN
    return {p, crc8(p)};
`else
    return p;
`endif
  endfunction

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  hold_q, hold_d, shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          seq_q, seq_d;
  logic                ovr_q, ovr_d, rdy_q, rdy_d;
  logic [4*WORD_W-1:0] pend_q, pend_d, words;
  logic                pend_full_q, pend_full_d, pend_ovr_q, pend_ovr_d;
  logic                to_pend;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    ovr_d       = ovr_q;
    rdy_d       = rdy_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    pend_ovr_d  = pend_ovr_q;
    to_pend     = 1'b0;
    words       = {count_up, count_down, count_rundown, count_osc};

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          shift_d = hold_q;
          cnt_d   = '0;
          state_d = ST_SHIFT;
          to_pend = 1'b1;
        end
      end
      ST_SHIFT: begin
        to_pend = 1'b1;
        if (sclk_fall) begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        if (cs_rise) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        // A short frame leaves the result unread; only a complete frame consumes it.
        if (cnt_q >= FRAME_CNT) begin
          rdy_d = 1'b0;
          ovr_d = 1'b0;
          if (pend_full_q) begin
            seq_d       = seq_q + 3'd1;
            ovr_d       = pend_ovr_q;
            hold_d      = build_frame(pend_q, seq_d, ovr_d);
            rdy_d       = 1'b1;
            pend_full_d = 1'b0;
            pend_ovr_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Applied after any pending transfer so a FINISH-cycle result sees the updated data_rdy.
    if (result_valid) begin
      if (to_pend) begin
        if (pend_full_q) begin
          ovr_d      = 1'b1;
          pend_ovr_d = 1'b1;
        end
        pend_d      = words;
        pend_full_d = 1'b1;
      end else begin
        if (rdy_d) ovr_d = 1'b1;
        seq_d  = seq_d + 3'd1;
        hold_d = build_frame(words, seq_d, ovr_d);
        rdy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      seq_q       <= '0;
      ovr_q       <= 1'b0;
      rdy_q       <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      pend_ovr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      ovr_q       <= ovr_d;
      rdy_q       <= rdy_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      pend_ovr_q  <= pend_ovr_d;
    end
  end

  assign spi_miso = (state_q == ST_SHIFT) ? shift_q[FRAME_W-1] : 1'b0;
  assign data_rdy = rdy_q;

endmodule
